// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the 16-bit signed calculator back-end.
// Holds the default operand width, the multiply FSM state type and the
// iteration-counter width used by the sequential multiplier.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Counter must be able to hold the value WIDTH, hence WIDTH+1 codes.
  localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mult_state_t;

  // Counter width for a non-default WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_core.sv
// seq_mult_core: iterative signed shift-and-add multiplier.
// Operands are converted to magnitudes, multiplied over WIDTH cycles, and the
// sign is applied on the final iteration together with overflow detection.
// Ports:
//   clk, nRST            clock (rising edge), async active-low reset
//   mul_in1, mul_in2     signed multiplicand / multiplier
//   mul_start            start request, accepted only in IDLE
//   mul_out              low WIDTH bits of the signed product (held)
//   mul_finish           one-cycle result-valid pulse
//   mul_ovf              product does not fit in WIDTH signed bits (held)
//   mul_busy             multiply in progress
module seq_mult_core
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [WIDTH-1:0] mul_in1,
  input  logic [WIDTH-1:0] mul_in2,
  input  logic             mul_start,
  output logic [WIDTH-1:0] mul_out,
  output logic             mul_finish,
  output logic             mul_ovf,
  output logic             mul_busy
);

  localparam int CW = (WIDTH == DEFAULT_WIDTH) ? CNT_W : cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  mult_state_t      state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic             finish_q, finish_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] abs1, abs2;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    prod;

  // Magnitudes as unsigned values; the most negative input maps to 2^(WIDTH-1).
  assign abs1 = mul_in1[WIDTH-1] ? (WIDTH'(0) - mul_in1) : mul_in1;
  assign abs2 = mul_in2[WIDTH-1] ? (WIDTH'(0) - mul_in2) : mul_in2;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    finish_d = 1'b0;
    busy_d   = busy_q;
    prod     = '0;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (mul_start) begin
          mcand_d  = {{WIDTH{1'b0}}, abs1};
          mplier_d = abs2;
          sign_d   = mul_in1[WIDTH-1] ^ mul_in2[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last iteration: apply sign and publish the result in the same edge.
        if (cnt_q == CW'(WIDTH - 1)) begin
          prod     = sign_q ? (PW'(0) - acc_step) : acc_step;
          out_d    = prod[WIDTH-1:0];
          // Fits in WIDTH signed bits only if the upper bits are a sign extension.
          ovf_d    = !((&prod[PW-1:WIDTH-1]) || !(|prod[PW-1:WIDTH-1]));
          finish_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_out    = out_q;
  assign mul_finish = finish_q;
  assign mul_ovf    = ovf_q;
  assign mul_busy   = busy_q;

endmodule

// File: rtl/addition_multiply.sv
// addition_multiply: arithmetic back-end of the 16-bit signed calculator.
// A single-cycle add/subtract path and an iterative multiply path, each with
// its own start/finish handshake and held result registers.
// Ports:
//   clk, nRST                 clock (rising edge), async active-low reset
//   add_in1, add_in2, sub     add/sub operands, 0 = A+B, 1 = A-B
//   add_start                 sample add operands this edge
//   add_out, add_finish, add_ovf  registered result, valid pulse, signed overflow
//   mul_in1, mul_in2, mul_start   multiply operands and start
//   mul_out, mul_finish, mul_ovf, mul_busy  multiply result and status
module addition_multiply
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  input  logic             sub,
  input  logic             add_start,
  output logic [WIDTH-1:0] add_out,
  output logic             add_finish,
  output logic             add_ovf,
  input  logic [WIDTH-1:0] mul_in1,
  input  logic [WIDTH-1:0] mul_in2,
  input  logic             mul_start,
  output logic [WIDTH-1:0] mul_out,
  output logic             mul_finish,
  output logic             mul_ovf,
  output logic             mul_busy
);

  logic [WIDTH-1:0] add_out_q, add_out_d;
  logic             add_ovf_q, add_ovf_d;
  logic             add_finish_q, add_finish_d;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;

  // Subtraction as A + ~B + 1; the effective B sign is B's msb flipped by sub.
  assign b_eff = sub ? ~add_in2 : add_in2;
  assign sum   = add_in1 + b_eff + WIDTH'(sub);

  always_comb begin
    add_out_d    = add_out_q;
    add_ovf_d    = add_ovf_q;
    add_finish_d = 1'b0;
    if (add_start) begin
      add_out_d    = sum;
      add_ovf_d    = (add_in1[WIDTH-1] == (add_in2[WIDTH-1] ^ sub)) &&
                     (sum[WIDTH-1] != add_in1[WIDTH-1]);
      add_finish_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      add_out_q    <= '0;
      add_ovf_q    <= 1'b0;
      add_finish_q <= 1'b0;
    end else begin
      add_out_q    <= add_out_d;
      add_ovf_q    <= add_ovf_d;
      add_finish_q <= add_finish_d;
    end
  end

  assign add_out    = add_out_q;
  assign add_ovf    = add_ovf_q;
  assign add_finish = add_finish_q;

  seq_mult_core #(.WIDTH(WIDTH)) u_mult (
    .clk        (clk),
    .nRST       (nRST),
    .mul_in1    (mul_in1),
    .mul_in2    (mul_in2),
    .mul_start  (mul_start),
    .mul_out    (mul_out),
    .mul_finish (mul_finish),
    .mul_ovf    (mul_ovf),
    .mul_busy   (mul_busy)
  );

endmodule

// File: tb/tb_addition_multiply.sv
// tb_addition_multiply: scoreboard bench for addition_multiply.
module tb_addition_multiply;

  typedef struct packed {
    logic [15:0] val;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        nRST;
  logic [15:0] add_in1, add_in2;
  logic        sub, add_start;
  logic [15:0] add_out;
  logic        add_finish, add_ovf;
  logic [15:0] mul_in1, mul_in2;
  logic        mul_start;
  logic [15:0] mul_out;
  logic        mul_finish, mul_ovf, mul_busy;

  int nChecks = 0;
  int nFails  = 0;
  exp_t addQ[$];
  exp_t mulQ[$];

  addition_multiply #(.WIDTH(16)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .sub        (sub),
    .add_start  (add_start),
    .add_out    (add_out),
    .add_finish (add_finish),
    .add_ovf    (add_ovf),
    .mul_in1    (mul_in1),
    .mul_in2    (mul_in2),
    .mul_start  (mul_start),
    .mul_out    (mul_out),
    .mul_finish (mul_finish),
    .mul_ovf    (mul_ovf),
    .mul_busy   (mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference models use full-precision integer arithmetic and range checks.
  function automatic exp_t add_model(input logic signed [15:0] a, input logic signed [15:0] b,
                                     input logic s);
    int r;
    exp_t e;
    r = s ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    e.val = r[15:0];
    e.ovf = (r > 32767) || (r < -32768);
    return e;
  endfunction

  function automatic exp_t mul_model(input logic signed [15:0] a, input logic signed [15:0] b);
    longint p;
    exp_t e;
    p = longint'(a) * longint'(b);
    e.val = p[15:0];
    e.ovf = (p > 32767) || (p < -32768);
    return e;
  endfunction

  task automatic test_reset();
    nRST = 1'b0; add_in1 = '0; add_in2 = '0; sub = 1'b0; add_start = 1'b0;
    mul_in1 = '0; mul_in2 = '0; mul_start = 1'b0;
    #1;
    nChecks++;
    if ({add_out, add_finish, add_ovf, mul_out, mul_finish, mul_ovf, mul_busy} !== 36'd0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got %h/%b/%b %h/%b/%b/%b want all 0",
               add_out, add_finish, add_ovf, mul_out, mul_finish, mul_ovf, mul_busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
  endtask

  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input string name);
    exp_t e;
    @(negedge clk);
    add_in1 = a; add_in2 = b; sub = s; add_start = 1'b1;
    addQ.push_back(add_model(a, b, s));
    @(posedge clk); #1;
    e = addQ.pop_front();
    nChecks++;
    if (add_out !== e.val || add_ovf !== e.ovf || add_finish !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL %s: got out=%h ovf=%b fin=%b want out=%h ovf=%b fin=1",
               name, add_out, add_ovf, add_finish, e.val, e.ovf);
    end
    @(negedge clk);
    add_start = 1'b0; add_in1 = 16'h1234; add_in2 = 16'h4321;
    @(posedge clk); #1;
    nChecks++;
    if (add_finish !== 1'b0 || add_out !== e.val || add_ovf !== e.ovf) begin
      nFails++;
      $display("[TB] FAIL %s_hold: got out=%h ovf=%b fin=%b want out=%h ovf=%b fin=0",
               name, add_out, add_ovf, add_finish, e.val, e.ovf);
    end
  endtask

  task automatic test_add();
    do_add(16'd3, 16'd4, 1'b0, "add_3p4");
    do_add(16'd5, 16'd9, 1'b1, "sub_5m9");
    do_add(16'h7FFF, 16'd1, 1'b0, "add_ovf_pos");
    do_add(16'h8000, 16'd1, 1'b1, "sub_ovf_neg");
    do_add(16'h0000, 16'h8000, 1'b1, "sub_min");
  endtask

  task automatic test_add_back_to_back();
    exp_t e;
    @(negedge clk);
    add_start = 1'b1; add_in1 = 16'd100; add_in2 = 16'd23; sub = 1'b0;
    addQ.push_back(add_model(16'd100, 16'd23, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = addQ.pop_front();
      nChecks++;
      if (add_out !== e.val || add_ovf !== e.ovf || add_finish !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL add_b2b_%0d: got out=%h ovf=%b fin=%b want out=%h ovf=%b fin=1",
                 i, add_out, add_ovf, add_finish, e.val, e.ovf);
      end
      @(negedge clk);
      add_in1 = 16'(-200 * (i + 1)); add_in2 = 16'(i + 7); sub = i[0];
      addQ.push_back(add_model(add_in1, add_in2, sub));
    end
    add_start = 1'b0;
    addQ.delete();
    @(posedge clk); #1;
  endtask

  // Watches the multiplier after its start edge, with mul_start already low.
  task automatic wait_mul_done(input string name);
    exp_t e;
    int finCyc;
    finCyc = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (mul_finish === 1'b1) begin
        finCyc = cyc;
        break;
      end
      nChecks++;
      if (mul_busy !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL %s_busy cycle %0d: got %b want 1", name, cyc, mul_busy);
      end
    end
    nChecks++;
    if (finCyc != 16) begin
      nFails++;
      $display("[TB] FAIL %s_latency: got %0d cycles want 16", name, finCyc);
    end
    e = (mulQ.size() > 0) ? mulQ.pop_front() : '0;
    nChecks++;
    if (mul_out !== e.val || mul_ovf !== e.ovf || mul_busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL %s_result: got out=%h ovf=%b busy=%b want out=%h ovf=%b busy=0",
               name, mul_out, mul_ovf, mul_busy, e.val, e.ovf);
    end
    @(posedge clk); #1;
    nChecks++;
    if (mul_finish !== 1'b0 || mul_out !== e.val || mul_ovf !== e.ovf) begin
      nFails++;
      $display("[TB] FAIL %s_pulse: got fin=%b out=%h ovf=%b want fin=0 out=%h ovf=%b",
               name, mul_finish, mul_out, mul_ovf, e.val, e.ovf);
    end
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input string name);
    @(negedge clk);
    mul_in1 = a; mul_in2 = b; mul_start = 1'b1;
    mulQ.push_back(mul_model(a, b));
    @(posedge clk); #1;
    nChecks++;
    if (mul_busy !== 1'b1 || mul_finish !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL %s_start: got busy=%b fin=%b want busy=1 fin=0",
               name, mul_busy, mul_finish);
    end
    @(negedge clk);
    mul_start = 1'b0;
    mul_in1 = 16'($urandom); mul_in2 = 16'($urandom);
    wait_mul_done(name);
  endtask

  task automatic test_mul_basic();
    run_mul(16'd5, 16'd10, "mul_5x10");
  endtask

  task automatic test_mul_signs();
    run_mul(16'(-3), 16'd7, "mul_m3x7");
    run_mul(16'(-4), 16'(-6), "mul_m4xm6");
    run_mul(16'd0, 16'(-1234), "mul_0xm1234");
  endtask

  task automatic test_mul_ovf();
    run_mul(16'd300, 16'd300, "mul_300x300");
    run_mul(16'h8000, 16'hFFFF, "mul_minxm1");
    run_mul(16'h8000, 16'd1, "mul_minx1");
  endtask

  task automatic test_handshake();
    exp_t e;
    @(negedge clk);
    mul_in1 = 16'd7; mul_in2 = 16'd9; mul_start = 1'b1;
    mulQ.push_back(mul_model(16'd7, 16'd9));
    @(posedge clk); #1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      mul_start = (c == 5) || (c == 16);
      if (c == 5)  begin mul_in1 = 16'd100; mul_in2 = 16'd100; end
      if (c == 16) begin mul_in1 = 16'(-2); mul_in2 = 16'd11; end
      add_start = (c == 8);
      if (c == 8) begin
        add_in1 = 16'd1000; add_in2 = 16'd50; sub = 1'b1;
        addQ.push_back(add_model(16'd1000, 16'd50, 1'b1));
      end
      @(posedge clk); #1;
      if (c == 8) begin
        e = addQ.pop_front();
        nChecks++;
        if (add_out !== e.val || add_ovf !== e.ovf || add_finish !== 1'b1) begin
          nFails++;
          $display("[TB] FAIL hs_add_during_run: got out=%h ovf=%b fin=%b want out=%h ovf=%b fin=1",
                   add_out, add_ovf, add_finish, e.val, e.ovf);
        end
      end
      if (c < 16) begin
        nChecks++;
        if (mul_busy !== 1'b1 || mul_finish !== 1'b0) begin
          nFails++;
          $display("[TB] FAIL hs_run cycle %0d: got busy=%b fin=%b want busy=1 fin=0",
                   c, mul_busy, mul_finish);
        end
      end else begin
        e = mulQ.pop_front();
        nChecks++;
        if (mul_finish !== 1'b1 || mul_busy !== 1'b0 || mul_out !== e.val || mul_ovf !== e.ovf) begin
          nFails++;
          $display("[TB] FAIL hs_finish: got fin=%b busy=%b out=%h ovf=%b want fin=1 busy=0 out=%h ovf=%b",
                   mul_finish, mul_busy, mul_out, mul_ovf, e.val, e.ovf);
        end
      end
    end
    // mul_start is still high here, so the next edge is the restart.
    add_start = 1'b0;
    mulQ.push_back(mul_model(16'(-2), 16'd11));
    @(posedge clk); #1;
    nChecks++;
    if (mul_busy !== 1'b1 || mul_finish !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL hs_restart: got busy=%b fin=%b want busy=1 fin=0", mul_busy, mul_finish);
    end
    @(negedge clk);
    mul_start = 1'b0;
    wait_mul_done("hs_second");
  endtask

  task automatic test_reset_mid_mul();
    int badCnt;
    @(negedge clk);
    mul_in1 = 16'd5; mul_in2 = 16'd10; mul_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    mul_start = 1'b0;
    repeat (7) @(posedge clk);
    @(posedge clk); #1;
    nRST = 1'b0;
    #1;
    nChecks++;
    if ({add_out, add_finish, add_ovf, mul_out, mul_finish, mul_ovf, mul_busy} !== 36'd0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_mul: got %h/%b/%b %h/%b/%b/%b want all 0",
               add_out, add_finish, add_ovf, mul_out, mul_finish, mul_ovf, mul_busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    badCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mul_finish !== 1'b0 || mul_busy !== 1'b0) badCnt++;
    end
    nChecks++;
    if (badCnt != 0) begin
      nFails++;
      $display("[TB] FAIL reset_no_finish: got %0d cycles with finish/busy want 0", badCnt);
    end
    run_mul(16'd5, 16'd10, "mul_after_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_back_to_back();
    test_mul_basic();
    test_mul_signs();
    test_mul_ovf();
    test_handshake();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/addition_multiply.md
Name: addition_multiply

Overview:
Arithmetic back-end of the 16-bit signed calculator, driven by the general controller.
- Add/subtract path: single-cycle.
- Multiply path: iterative, shift-and-add.
- Each path has its own start/finish handshake and holds its result register for the controller.
- Operands and results are two's-complement.

Parameters:
- WIDTH, 16, operand/result width in bits. Multiply iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- add_in1  in  WIDTH  add/sub operand A, signed.
- add_in2  in  WIDTH  add/sub operand B, signed.
- sub  in  1  0 = A+B, 1 = A-B.
- add_start  in  1  sample add operands this edge.
- add_out  out  WIDTH  add/sub result, registered.
- add_finish  out  1  add result valid pulse.
- add_ovf  out  1  signed overflow of last add/sub.
- mul_in1  in  WIDTH  multiplicand, signed.
- mul_in2  in  WIDTH  multiplier, signed.
- mul_start  in  1  start multiply, accepted only when idle.
- mul_out  out  WIDTH  low WIDTH bits of signed product, registered.
- mul_finish  out  1  multiply result valid pulse.
- mul_ovf  out  1  product does not fit in WIDTH signed.
- mul_busy  out  1  multiply in progress.

Behaviour:

Reset (nRST low, async, any time including mid-multiply):
- All outputs cleared to 0; the multiply FSM goes to IDLE.
- Partial product is discarded; no finish is issued after reset releases.

Add path:
- On an edge with add_start=1: add_out <= A+B (sub=0) or A-B (sub=1), modulo 2^WIDTH.
- Same edge: add_ovf <= signed overflow (operand signs agree, with B negated for sub, and result sign differs); add_finish <= 1.
- On an edge with add_start=0: add_finish <= 0; add_out and add_ovf hold.
- Latency: result visible the cycle after the start edge.
- add_start held high produces a new result every cycle, with add_finish staying high.

Multiply FSM, states IDLE and RUN:
- IDLE, mul_start=1 at edge k:
  - latch |mul_in1| and |mul_in2| as unsigned WIDTH-bit values (|-32768| = 32768);
  - latch sign = msb1 XOR msb2;
  - clear the 2*WIDTH accumulator and iteration counter;
  - mul_busy <= 1, mul_finish <= 0; go to RUN.
- RUN, edges k+1 .. k+WIDTH:
  - each edge: if the multiplier lsb is 1, add the shifted multiplicand to the accumulator;
  - then shift the multiplicand left and the multiplier right; counter++.
- At edge k+WIDTH, with the final iteration folded in:
  - form P = sign ? -acc : acc;
  - mul_out <= P[WIDTH-1:0];
  - mul_ovf <= 1 iff P lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1];
  - mul_finish <= 1, mul_busy <= 0; go to IDLE.
- Latency: mul_finish is visible WIDTH cycles (16) after the start edge. It is a one-cycle pulse, cleared on the next edge unless a new completion occurs.
- mul_start while RUN, including at edge k+WIDTH: ignored.
- Earliest restart: edge k+WIDTH+1.
- Operands may change after the start edge without affecting the result.
- mul_out and mul_ovf hold until the next completion.

Independence:
- The two paths may operate simultaneously; neither path's signals affect the other.

Decomposition:
- Package calc_pkg holds:
  - WIDTH default (16);
  - mult_state_t enum {IDLE, RUN};
  - a localparam for the counter width, $clog2(WIDTH+1).
- The add path is inline in addition_multiply.
- Sub-module seq_mult_core holds the multiply FSM, accumulator, counter, sign fix-up and overflow detection.

Test Plan:
- Reset mid-multiply: start 5*10, assert nRST low at cycle 8, release → all outputs 0, no mul_finish pulse, next 5*10 yields 50.
- Add/sub: 3+4 → add_out=7, add_finish high the next cycle only; 5-9 → 0xFFFC (-4), ovf=0; 0x7FFF+1 → 0x8000, ovf=1; 0x8000-1 → 0x7FFF, ovf=1.
- Multiply basic: 5*10 → mul_finish exactly 16 cycles after the start edge, mul_out=50, ovf=0; mul_busy high for those 16 cycles.
- Signs: -3*7 → 0xFFEB (-21); -4*-6 → 24; 0*-1234 → 0; all with ovf=0.
- Overflow: 300*300 → mul_out=0x5F90, ovf=1; -32768*-1 → 0x8000, ovf=1; -32768*1 → 0x8000, ovf=0.
- Handshake: mul_start re-pulsed during RUN and at the finish edge → ignored, result unchanged; the next start accepted one edge later. Simultaneous add_start during RUN → add result correct, multiply unaffected.
